sma_lsu: RTL and testbench
==========================

Name: sma_lsu

Overview:
- Load/store stage directly downstream of the SMA bounds engine. It consumes the bounded address and the overflow/underflow flags that engine produces, and raises a bounds or alignment exception instead of touching memory when a check fails.
- Otherwise it issues one byte-lane memory request over a valid/ready interface, waits for the response, and for loads returns a sign- or zero-extended writeback.
- One access in flight; registered outputs.

Parameters:
- WORD_WIDTH, 64, data/address word width (8 byte lanes).
- PTR_WIDTH, 48, meaningful address bits driven on mem_addr.
- REG_ADDR_WIDTH, 5, destination register index width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  access request from execute.
- req_ready  out  1  high only in IDLE.
- req_store  in  1  1 = store, 0 = load.
- req_signed  in  1  loads: sign-extend when 1, zero-extend when 0.
- access_type  in  3  log2 of access bytes; 0..3 legal.
- sma_address  in  WORD_WIDTH  bounded address from the SMA engine.
- overflow  in  1  SMA overflow flag.
- underflow  in  1  SMA underflow flag.
- store_data  in  WORD_WIDTH  right-aligned store value.
- req_rd  in  REG_ADDR_WIDTH  load destination.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_we  out  1  write enable.
- mem_addr  out  PTR_WIDTH  {sma_address[PTR_WIDTH-1:3], 3'b000}.
- mem_wstrb  out  8  byte-lane strobes.
- mem_wdata  out  WORD_WIDTH  lane-shifted store data.
- mem_rsp_valid  in  1  response (read data or store ack).
- mem_rdata  in  WORD_WIDTH  full 8-byte read word.
- wb_valid  out  1  load result pulse.
- wb_rd  out  REG_ADDR_WIDTH  load destination.
- wb_data  out  WORD_WIDTH  extended load data.
- done  out  1  one-cycle pulse when any access retires (normal or exception).
- exc_valid  out  1  exception pulse.
- exc_code  out  2  01 overflow, 10 underflow, 11 misaligned/illegal.
- exc_addr  out  WORD_WIDTH  faulting sma_address.

Behaviour:
- Reset values:
  - State IDLE; req_ready=1.
  - All other outputs 0, including mem_req_valid, wb_valid, exc_valid and done.
  - Internal request registers cleared.
- States: IDLE, EXC, REQ, WAIT_RSP, RETIRE.
- IDLE:
  - Accepts on req_valid && req_ready and latches all request inputs.
  - Next state EXC if a check fails, else REQ.
- Check priority: overflow (01), then underflow (10), then misaligned or illegal (11).
  - Misaligned means access_type>3, or sma_address[2:0] & ((1<<access_type)-1) != 0.
- EXC (1 cycle):
  - exc_valid=1, done=1, exc_code/exc_addr driven.
  - mem_req_valid stays 0; no memory side effect.
  - Next state IDLE.
- REQ:
  - mem_req_valid=1; mem_we, mem_addr, mem_wstrb and mem_wdata are held stable until mem_req_ready.
  - On handshake, next state WAIT_RSP.
- Lane rules, with off = sma_address[2:0] and n = 1<<access_type bytes:
  - mem_wstrb = ((1<<n)-1) << off, for loads and stores alike.
  - mem_wdata = store_data << (8*off); bits outside the strobe are don't-care, but the bench expects zero.
- WAIT_RSP:
  - On mem_rsp_valid, next state RETIRE.
  - Loads capture (mem_rdata >> 8*off), masked to n bytes and extended per req_signed; access_type 3 passes through unchanged.
- mem_rsp_valid in any other state is ignored.
- RETIRE (1 cycle):
  - done=1.
  - Loads also drive wb_valid=1 with wb_rd/wb_data; stores drive wb_valid=0.
  - Next state IDLE.
- Latency:
  - Exception: accept at cycle 0, exc_valid at 1, req_ready at 2.
  - Memory access: accept at 0, mem_req_valid from 1; response in cycle R gives wb_valid/done in R+1 and req_ready in R+2.
- rst in any state:
  - Returns to IDLE next edge and drops the in-flight access; no wb_valid, exc_valid or done.
  - The memory side is reset with the same rst.
- Simultaneous overflow and underflow report 01.

Decomposition:
- Shared package sma_pkg holds:
  - Tagged-pointer field widths (BSIZE_WIDTH=6, LENGTH_WIDTH=4, PTR_WIDTH=48).
  - Access-type encodings (BYTE=0, HALF=1, WORD=2, DOUBLE=3).
  - Exception codes EXC_OVERFLOW=2'b01, EXC_UNDERFLOW=2'b10, EXC_MISALIGN=2'b11.
  - The state enumeration.
- One combinational sub-module, sma_lane_align: from off, access_type, store_data, rdata and signed it produces wstrb, wdata and the extended load data.

Test Plan:
- Store access_type=2, sma_address=0x1004, store_data=0xDEADBEEF, mem_req_ready=1, ack after 2 cycles -> mem_wstrb=0xF0, mem_wdata=0xDEADBEEF_00000000, mem_addr=0x1000, done pulse, wb_valid stays 0.
- Signed byte load at 0x1003, rdata=0x00000000_80000000 -> wb_data=0xFFFFFFFF_FFFFFF80; the same access with req_signed=0 -> wb_data=0x80.
- overflow=1 on a load at 0x2FF8 -> exc_valid with exc_code=01, exc_addr=0x2FF8, mem_req_valid never high, req_ready back 2 cycles after accept.
- Halfword load at 0x1001 -> exc_code=11; access_type=5 at 0x1000 -> exc_code=11.
- mem_req_ready held low 3 cycles -> mem_req_valid/addr/wstrb/wdata stable throughout; exactly one handshake.
- rst during WAIT_RSP, then mem_rsp_valid the cycle after -> no wb_valid/done; req_ready=1; next request completes normally.

Source files
------------

// File: rtl/sma_pkg.sv
// Shared definitions for the SMA load/store path: pointer field widths,
// access-size encodings, exception codes and the LSU state set.
package sma_pkg;

  localparam int BSIZE_WIDTH  = 6;
  localparam int LENGTH_WIDTH = 4;
  localparam int PTR_WIDTH    = 48;

  // log2 of the access size in bytes
  typedef enum logic [1:0] {
    BYTE   = 2'd0,
    HALF   = 2'd1,
    WORD   = 2'd2,
    DOUBLE = 2'd3
  } access_e;

  localparam logic [1:0] EXC_NONE      = 2'b00;
  localparam logic [1:0] EXC_OVERFLOW  = 2'b01;
  localparam logic [1:0] EXC_UNDERFLOW = 2'b10;
  localparam logic [1:0] EXC_MISALIGN  = 2'b11;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    EXC      = 3'd1,
    REQ      = 3'd2,
    WAIT_RSP = 3'd3,
    RETIRE   = 3'd4
  } state_e;

  // Illegal size codes and addresses not naturally aligned to the size fault.
  function automatic logic is_misaligned(input logic [2:0] off,
                                         input logic [2:0] access_type);
    logic [2:0] low_mask;
    low_mask = 3'b000;
    case (access_type)
      3'd0:    low_mask = 3'b000;
      3'd1:    low_mask = 3'b001;
      3'd2:    low_mask = 3'b011;
      3'd3:    low_mask = 3'b111;
      default: return 1'b1;
    endcase
    return (off & low_mask) != 3'b000;
  endfunction

endpackage

// File: rtl/sma_lane_align.sv
// Byte-lane steering between a right-aligned register value and an
// 8-lane memory word: store strobes/data and extended load data.
module sma_lane_align
  import sma_pkg::*;
#(
  parameter int WORD_WIDTH = 64
) (
  input  logic [2:0]              off_i,
  input  access_e                 access_type_i,
  input  logic [WORD_WIDTH-1:0]   store_data_i,
  input  logic [WORD_WIDTH-1:0]   rdata_i,
  input  logic                    signed_i,
  output logic [WORD_WIDTH/8-1:0] wstrb_o,
  output logic [WORD_WIDTH-1:0]   wdata_o,
  output logic [WORD_WIDTH-1:0]   load_o
);

  localparam int LANES = WORD_WIDTH / 8;

  logic [LANES-1:0]      size_mask;
  logic [LANES-1:0]      strb;
  logic [WORD_WIDTH-1:0] st_shifted;
  logic [WORD_WIDTH-1:0] ld_shifted;

  // Lane steering and load extension; purely combinational.
  always_comb begin
    // NOTE: every output of a combinational block gets a default up front so
    // no path through the case statements can leave a latch behind.
    size_mask = '0;
    wdata_o   = '0;
    load_o    = '0;

    case (access_type_i)
      BYTE:    size_mask = LANES'(8'h01);
      HALF:    size_mask = LANES'(8'h03);
      WORD:    size_mask = LANES'(8'h0F);
      default: size_mask = LANES'(8'hFF);
    endcase
    strb = size_mask << off_i;

    // Bytes outside the strobe are forced to zero rather than left as junk.
    st_shifted = store_data_i << {off_i, 3'b000};
    for (int i = 0; i < LANES; i++) begin
      wdata_o[8*i +: 8] = strb[i] ? st_shifted[8*i +: 8] : 8'h00;
    end

    ld_shifted = rdata_i >> {off_i, 3'b000};
    case (access_type_i)
      BYTE:    load_o = {{(WORD_WIDTH-8){signed_i & ld_shifted[7]}},   ld_shifted[7:0]};
      HALF:    load_o = {{(WORD_WIDTH-16){signed_i & ld_shifted[15]}}, ld_shifted[15:0]};
      WORD:    load_o = {{(WORD_WIDTH-32){signed_i & ld_shifted[31]}}, ld_shifted[31:0]};
      default: load_o = ld_shifted;
    endcase
  end

  assign wstrb_o = strb;

endmodule

// File: rtl/sma_lsu.sv
// Load/store stage after the SMA bounds engine: traps bounds/alignment
// faults, otherwise performs one byte-lane memory access at a time.
module sma_lsu
  import sma_pkg::*;
#(
  parameter int WORD_WIDTH     = 64,
  parameter int PTR_WIDTH      = 48,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_store,
  input  logic                      req_signed,
  input  logic [2:0]                access_type,
  input  logic [WORD_WIDTH-1:0]     sma_address,
  input  logic                      overflow,
  input  logic                      underflow,
  input  logic [WORD_WIDTH-1:0]     store_data,
  input  logic [REG_ADDR_WIDTH-1:0] req_rd,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic                      mem_we,
  output logic [PTR_WIDTH-1:0]      mem_addr,
  output logic [7:0]                mem_wstrb,
  output logic [WORD_WIDTH-1:0]     mem_wdata,
  input  logic                      mem_rsp_valid,
  input  logic [WORD_WIDTH-1:0]     mem_rdata,
  output logic                      wb_valid,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd,
  output logic [WORD_WIDTH-1:0]     wb_data,
  output logic                      done,
  output logic                      exc_valid,
  output logic [1:0]                exc_code,
  output logic [WORD_WIDTH-1:0]     exc_addr
);

  state_e                    state_q, state_d;
  logic [1:0]                exc_d, exc_code_q;
  logic                      store_q, signed_q;
  access_e                   at_q;
  logic [WORD_WIDTH-1:0]     addr_q, sdata_q, load_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;

  logic [7:0]                lane_wstrb;
  logic [WORD_WIDTH-1:0]     lane_wdata, lane_load;

  wire accept = (state_q == IDLE) && req_valid;

  // Fault classification of the incoming request and next-state selection.
  always_comb begin
    state_d = state_q;
    exc_d   = EXC_NONE;
    if (overflow)                                          exc_d = EXC_OVERFLOW;
    else if (underflow)                                    exc_d = EXC_UNDERFLOW;
    else if (is_misaligned(sma_address[2:0], access_type)) exc_d = EXC_MISALIGN;

    case (state_q)
      IDLE:     if (req_valid) state_d = (exc_d != EXC_NONE) ? EXC : REQ;
      EXC:      state_d = IDLE;
      REQ:      if (mem_req_ready) state_d = WAIT_RSP;
      WAIT_RSP: if (mem_rsp_valid) state_d = RETIRE;
      RETIRE:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Request capture at accept and load-data capture on the read response.
  always_ff @(posedge clk) begin
    if (rst) begin
      store_q    <= 1'b0;
      signed_q   <= 1'b0;
      at_q       <= BYTE;
      addr_q     <= '0;
      sdata_q    <= '0;
      rd_q       <= '0;
      exc_code_q <= EXC_NONE;
      load_q     <= '0;
    end else begin
      if (accept) begin
        store_q    <= req_store;
        signed_q   <= req_signed;
        at_q       <= access_e'(access_type[1:0]);
        addr_q     <= sma_address;
        sdata_q    <= store_data;
        rd_q       <= req_rd;
        exc_code_q <= exc_d;
      end
      if (state_q == WAIT_RSP && mem_rsp_valid && !store_q) begin
        load_q <= lane_load;
      end
    end
  end

  sma_lane_align #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_lane_align (
    .off_i         (addr_q[2:0]),
    .access_type_i (at_q),
    .store_data_i  (sdata_q),
    .rdata_i       (mem_rdata),
    .signed_i      (signed_q),
    .wstrb_o       (lane_wstrb),
    .wdata_o       (lane_wdata),
    .load_o        (lane_load)
  );

  // Every output decodes from registers only; lane fields are gated to zero
  // outside REQ so idle and reset values are clean.
  assign req_ready     = (state_q == IDLE);
  assign mem_req_valid = (state_q == REQ);
  assign mem_we        = mem_req_valid & store_q;
  assign mem_addr      = {addr_q[PTR_WIDTH-1:3], 3'b000};
  assign mem_wstrb     = mem_req_valid ? lane_wstrb : 8'h00;
  assign mem_wdata     = mem_req_valid ? lane_wdata : '0;
  assign wb_valid      = (state_q == RETIRE) && !store_q;
  assign wb_rd         = rd_q;
  assign wb_data       = load_q;
  assign done          = (state_q == EXC) || (state_q == RETIRE);
  assign exc_valid     = (state_q == EXC);
  assign exc_code      = exc_code_q;
  assign exc_addr      = addr_q;

endmodule

// File: tb/tb_sma_lsu.sv
// Randomized self-checking bench for sma_lsu against an arithmetic model.
module tb_sma_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_store, req_signed;
  logic [2:0]  access_type;
  logic [63:0] sma_address, store_data;
  logic        overflow, underflow;
  logic [4:0]  req_rd;
  logic        mem_req_valid, mem_req_ready, mem_we;
  logic [47:0] mem_addr;
  logic [7:0]  mem_wstrb;
  logic [63:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [63:0] mem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        done, exc_valid;
  logic [1:0]  exc_code;
  logic [63:0] exc_addr;

  int n_vec = 0;
  int n_err = 0;

  sma_lsu dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_signed(req_signed), .access_type(access_type), .sma_address(sma_address),
    .overflow(overflow), .underflow(underflow), .store_data(store_data), .req_rd(req_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .done(done),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_addr(exc_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [1:0] ref_code(input bit ov, input bit un,
                                          input int at, input logic [63:0] addr);
    if (ov) return 2'b01;
    if (un) return 2'b10;
    if (at > 3) return 2'b11;
    if ((addr % (64'd1 << at)) != 0) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [7:0] ref_wstrb(input int at, input logic [63:0] addr);
    int n = 1 << at;
    logic [15:0] m = ((16'd1 << n) - 16'd1) << (addr % 8);
    return m[7:0];
  endfunction

  function automatic logic [63:0] ref_wdata(input int at, input logic [63:0] addr,
                                            input logic [63:0] sd);
    int n = 1 << at;
    logic [127:0] v = {64'd0, sd};
    v = v & ((128'd1 << (8 * n)) - 128'd1);
    v = v << (8 * (addr % 8));
    return v[63:0];
  endfunction

  function automatic logic [63:0] ref_load(input int at, input logic [63:0] addr,
                                           input bit sg, input logic [63:0] rdata);
    int n = 1 << at;
    logic [127:0] mask = (128'd1 << (8 * n)) - 128'd1;
    logic [127:0] v = ({64'd0, rdata} >> (8 * (addr % 8))) & mask;
    if (sg && v[8*n-1]) v = v | ~mask;
    return v[63:0];
  endfunction

  // ---------------- access driver ----------------
  task automatic do_access(input bit st, input bit sg, input int at,
                           input logic [63:0] addr, input bit ov, input bit un,
                           input logic [63:0] sd, input logic [4:0] rd,
                           input logic [63:0] rdata, input int stall, input int rsp_delay);
    logic [1:0] code;
    bit hs;
    int cyc;
    code = ref_code(ov, un, at, addr);
    @(negedge clk);
    check("req_ready_idle", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; req_store = st; req_signed = sg; access_type = 3'(at);
    sma_address = addr; overflow = ov; underflow = un; store_data = sd; req_rd = rd;
    @(negedge clk);
    req_valid = 1'b0; overflow = 1'b0; underflow = 1'b0;
    sma_address = {$urandom, $urandom}; store_data = {$urandom, $urandom};
    if (code != 2'b00) begin
      check("exc_valid", {63'd0, exc_valid}, 64'd1);
      check("exc_code", {62'd0, exc_code}, {62'd0, code});
      check("exc_addr", exc_addr, addr);
      check("exc_done", {63'd0, done}, 64'd1);
      check("exc_no_mem", {63'd0, mem_req_valid}, 64'd0);
      @(negedge clk);
      check("exc_pulse_end", {62'd0, exc_valid, done}, 64'd0);
      check("exc_ready_back", {63'd0, req_ready}, 64'd1);
      return;
    end
    hs = 1'b0; cyc = 0;
    while (!hs && cyc < 50) begin
      check("mem_req_valid", {63'd0, mem_req_valid}, 64'd1);
      check("mem_we", {63'd0, mem_we}, {63'd0, st});
      check("mem_addr", 64'(mem_addr), {16'd0, addr[47:3], 3'b000});
      check("mem_wstrb", 64'(mem_wstrb), 64'(ref_wstrb(at, addr)));
      if (st) check("mem_wdata", mem_wdata, ref_wdata(at, addr, sd));
      check("req_busy", {63'd0, req_ready}, 64'd0);
      mem_req_ready = (cyc >= stall);
      @(negedge clk);
      hs = mem_req_ready;
      mem_req_ready = 1'b0;
      cyc++;
    end
    if (!hs) check("handshake_timeout", 64'd0, 64'd1);
    for (int i = 0; i < rsp_delay; i++) begin
      check("wait_no_req", {63'd0, mem_req_valid}, 64'd0);
      check("wait_no_done", {63'd0, done}, 64'd0);
      @(negedge clk);
    end
    mem_rsp_valid = 1'b1; mem_rdata = rdata;
    @(negedge clk);
    mem_rsp_valid = 1'b0; mem_rdata = {$urandom, $urandom};
    check("retire_done", {63'd0, done}, 64'd1);
    check("wb_valid", {63'd0, wb_valid}, {63'd0, !st});
    if (!st) begin
      check("wb_rd", 64'(wb_rd), 64'(rd));
      check("wb_data", wb_data, ref_load(at, addr, sg, rdata));
    end
    @(negedge clk);
    check("retire_end", {62'd0, wb_valid, done}, 64'd0);
    check("ready_after", {63'd0, req_ready}, 64'd1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_signed = 1'b0;
    access_type = 3'd0; sma_address = '0; overflow = 1'b0; underflow = 1'b0;
    store_data = '0; req_rd = '0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    mem_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", {63'd0, req_ready}, 64'd1);
    check("rst_ctrl", {58'd0, mem_req_valid, mem_we, wb_valid, done, exc_valid, 1'b0}, 64'd0);
    check("rst_wstrb", 64'(mem_wstrb), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_wdata", mem_wdata, 64'd0);
    check("rst_wb", wb_data | 64'(wb_rd), 64'd0);
    check("rst_exc", exc_addr | 64'(exc_code), 64'd0);
    rst = 1'b0;

    // Directed cases
    do_access(1, 0, 2, 64'h1004, 0, 0, 64'hDEADBEEF, 5'd0, 64'd0, 0, 2);
    do_access(0, 1, 0, 64'h1003, 0, 0, 64'd0, 5'd7, 64'h00000000_80000000, 0, 1);
    do_access(0, 0, 0, 64'h1003, 0, 0, 64'd0, 5'd9, 64'h00000000_80000000, 0, 0);
    do_access(0, 0, 3, 64'h2FF8, 1, 0, 64'd0, 5'd1, 64'd0, 0, 0);
    do_access(0, 0, 3, 64'h2FF8, 1, 1, 64'd0, 5'd1, 64'd0, 0, 0);
    do_access(0, 0, 1, 64'h1001, 0, 0, 64'd0, 5'd2, 64'd0, 0, 0);
    do_access(0, 0, 5, 64'h1000, 0, 0, 64'd0, 5'd2, 64'd0, 0, 0);
    do_access(0, 0, 3, 64'h1000, 0, 1, 64'd0, 5'd2, 64'd0, 0, 0);
    do_access(1, 0, 1, 64'h4006, 0, 0, 64'h1234_5678_9ABC_BEEF, 5'd0, 64'd0, 3, 1);
    do_access(0, 1, 3, 64'h4008, 0, 0, 64'd0, 5'd31, 64'h8000_0000_0000_0001, 3, 0);

    // Reset while waiting for the response drops the access entirely.
    begin
      @(negedge clk);
      req_valid = 1'b1; req_store = 1'b0; access_type = 3'd2;
      sma_address = 64'h5000; req_rd = 5'd4;
      @(negedge clk);
      req_valid = 1'b0; mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      check("rst_pre_wait", {63'd0, mem_req_valid}, 64'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      check("rst_mid_ready", {63'd0, req_ready}, 64'd1);
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      check("rst_drop", {61'd0, wb_valid, done, exc_valid}, 64'd0);
      check("rst_mid_ready2", {63'd0, req_ready}, 64'd1);
      @(negedge clk);
      check("rst_drop2", {61'd0, wb_valid, done, exc_valid}, 64'd0);
      do_access(0, 1, 1, 64'h5002, 0, 0, 64'd0, 5'd6, 64'h0000_0000_8001_0000, 1, 1);
    end

    // Randomized accesses
    for (int k = 0; k < 60; k++) begin
      int at;
      logic [63:0] addr;
      at = (($urandom % 8) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
      addr = {$urandom, $urandom};
      if (($urandom % 4) != 0 && at <= 3) addr = addr & ~((64'd1 << at) - 64'd1);
      // A stray response while idle must be ignored.
      if (($urandom % 5) == 0) begin
        @(negedge clk);
        mem_rsp_valid = 1'b1;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        check("stray_rsp", {62'd0, wb_valid, done}, 64'd0);
      end
      do_access($urandom % 2, $urandom % 2, at, addr,
                ($urandom % 10) == 0, ($urandom % 10) == 0,
                {$urandom, $urandom}, 5'($urandom), {$urandom, $urandom},
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
